// File: rtl/aes_pkg.sv
// Shared AES S-box constants and FSM state encoding for the S-box array.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] SBOX_FWD [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] SBOX_INV [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lookup: forward or inverse substitution of a single byte.
module aes_sbox_lane
   import aes_pkg::*;
(
   input  logic [7:0] data,
   input  logic       inv,
   output logic [7:0] result
);

   // Pick the inverse or forward table entry for this byte.
   always_comb begin
      result = inv ? SBOX_INV[data] : SBOX_FWD[data];
   end

endmodule

// File: rtl/aes_sbox_array.sv
// Multi-beat AES SubBytes engine: a word is accepted, substituted LANES bytes per
// cycle in a working register, then presented until downstream takes it.
module aes_sbox_array
   import aes_pkg::*;
#(
   parameter int NBYTES = 16,
   parameter int LANES  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_inv,
   input  logic [8*NBYTES-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_data
);

   localparam int SAFE_LANES = (LANES > 0) ? LANES : 1;
   localparam int BEATS      = NBYTES / SAFE_LANES;
   localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   // Reject lane counts that do not evenly tile the word.
   generate
      if ((LANES < 1) || (LANES > NBYTES) || ((NBYTES % SAFE_LANES) != 0)) begin : g_bad_params
         $error("aes_sbox_array: LANES must be in 1..NBYTES and divide NBYTES");
      end
   endgenerate

   state_t                     state_q;
   state_t                     state_d;
   logic [BEAT_W-1:0]          beat_q;
   logic [NBYTES-1:0][7:0]     work_q;
   logic                       mode_q;
   logic                       accept;
   logic                       last_beat;
   logic [IDX_W-1:0]           byte_idx [LANES];
   logic [7:0]                 lane_in  [LANES];
   logic [7:0]                 lane_out [LANES];

   // in_ready is gated by rst_n so nothing is offered while reset is held.
   assign in_ready  = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
   assign out_valid = (state_q == ST_DONE);
   assign out_data  = work_q;

   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign byte_idx[l] = IDX_W'(int'(beat_q) * LANES + l);
         assign lane_in[l]  = work_q[byte_idx[l]];
         aes_sbox_lane u_lane (
            .data   (lane_in[l]),
            .inv    (mode_q),
            .result (lane_out[l])
         );
      end
   endgenerate

   // State register; reset drops any in-flight word back to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: DONE hands straight to SUB when a new word is taken on the retiring edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_SUB;
         ST_SUB:  if (last_beat) state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = accept ? ST_SUB : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: latch word and mode on accept, then substitute one group of lanes per beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q <= '0;
         work_q <= '0;
         mode_q <= 1'b0;
      end else if (accept) begin
         beat_q <= '0;
         work_q <= in_data;
         mode_q <= in_inv;
      end else if (state_q == ST_SUB) begin
         for (int l = 0; l < LANES; l++) begin
            work_q[byte_idx[l]] <= lane_out[l];
         end
         beat_q <= last_beat ? '0 : beat_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_sbox_array.sv
// Self-checking bench for aes_sbox_array: table vectors, random words against a
// GF(2^8) reference model, back-pressure, back-to-back, mid-SUB reset and lane sweep.
module tb_aes_sbox_array;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         in_inv;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   logic         sw_valid;
   logic         rdy_l1, rdy_l16;
   logic         ov_l1, ov_l16;
   logic [127:0] od_l1, od_l16;

   int           n_vec;
   int           n_bad;
   logic [7:0]   ref_fwd [256];
   logic [7:0]   ref_inv [256];

   typedef struct {
      logic [127:0] data;
      logic         inv;
      logic [127:0] exp_data;
   } vec_t;

   vec_t vecs [6];

   aes_sbox_array #(.NBYTES(16), .LANES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   aes_sbox_array #(.NBYTES(16), .LANES(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy_l1), .in_inv(in_inv),
      .in_data(in_data), .out_valid(ov_l1), .out_ready(1'b1), .out_data(od_l1)
   );

   aes_sbox_array #(.NBYTES(16), .LANES(16)) dut_l16 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy_l16), .in_inv(in_inv),
      .in_data(in_data), .out_valid(ov_l16), .out_ready(1'b1), .out_data(od_l16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // Reference S-box from first principles: multiplicative inverse then affine map.
   task automatic build_model();
      logic [7:0] iv, s;
      for (int x = 0; x < 256; x++) begin
         iv = 8'h00;
         if (x != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            end
         end
         s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
         ref_fwd[x] = s;
         ref_inv[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] sub_word(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = inv ? ref_inv[d[8*i +: 8]] : ref_fwd[d[8*i +: 8]];
      end
      return r;
   endfunction

   function automatic logic [127:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   // Offer one word, flip in_inv afterwards, wait for the result and retire it.
   task automatic apply_stimulus(input logic [127:0] data, input logic inv,
                                 output logic [127:0] result, output int lat);
      int guard;
      out_ready = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b1;
      in_data  = data;
      in_inv   = inv;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_inv   = ~inv;
      in_data  = rand_word();
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      result = out_data;
      @(posedge clk); #1;
      in_inv = 1'b0;
   endtask

   initial begin
      logic [127:0] res, res2, d, held;
      logic [127:0] q[$];
      int lat, guard, last_acc, n_acc, lat1, lat16;
      logic acc, got1, got16;

      n_vec = 0; n_bad = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0;
      out_ready = 1'b1; sw_valid = 1'b0;

      vecs[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 128'h76ABD7FE2B670130C56F6BF27B777C63};
      vecs[1] = '{128'h76ABD7FE2B670130C56F6BF27B777C63, 1'b1, 128'h0F0E0D0C0B0A09080706050403020100};
      vecs[2] = '{{16{8'h53}}, 1'b0, {16{8'hED}}};
      vecs[3] = '{{16{8'h63}}, 1'b1, {16{8'h00}}};
      vecs[4] = '{{16{8'h00}}, 1'b0, {16{8'h63}}};
      vecs[5] = '{{16{8'h00}}, 1'b1, {16{8'h52}}};

      build_model();

      // Reset state
      #12;
      check_output("reset in_ready", in_ready, 0);
      check_output("reset out_valid", out_valid, 0);
      check_output("reset out_data", out_data, 0);
      #8 rst_n = 1'b1;
      @(posedge clk); #1;
      check_output("idle in_ready", in_ready, 1);
      check_output("idle out_valid", out_valid, 0);

      // Table-driven known-answer vectors
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(vecs[i].data, vecs[i].inv, res, lat);
         check_output($sformatf("vec%0d data", i), res, vecs[i].exp_data);
         check_output($sformatf("vec%0d latency", i), 128'(lat), 128'(4));
      end

      // Every byte value, forward then inverse
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(k*16 + i);
         apply_stimulus(d, 1'b0, res, lat);
         check_output($sformatf("fwd word%0d", k), res, sub_word(d, 1'b0));
         apply_stimulus(res, 1'b1, res2, lat);
         check_output($sformatf("roundtrip word%0d", k), res2, d);
      end

      // Random words, random mode
      for (int i = 0; i < 12; i++) begin
         d = rand_word();
         acc = 1'($urandom_range(1));
         apply_stimulus(d, acc, res, lat);
         check_output($sformatf("rand%0d data", i), res, sub_word(d, acc));
         check_output($sformatf("rand%0d latency", i), 128'(lat), 128'(4));
      end

      // Back-pressure: hold DONE for 10 cycles while a new word is offered
      out_ready = 1'b0;
      d = rand_word();
      in_valid = 1'b1; in_data = d; in_inv = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      check_output("hold latency", 128'(guard), 128'(4));
      held = out_data;
      check_output("hold data", held, sub_word(d, 1'b0));
      in_valid = 1'b1; in_data = ~d; in_inv = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check_output("hold out_data stable", out_data, held);
         check_output("hold out_valid", out_valid, 1);
         check_output("hold in_ready", in_ready, 0);
      end
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      check_output("release out_valid", out_valid, 0);
      check_output("release in_ready", in_ready, 1);

      // Back-to-back streaming with no idle bubble
      in_valid = 1'b1; out_ready = 1'b1;
      in_data = rand_word(); in_inv = 1'($urandom_range(1));
      last_acc = -1; n_acc = 0;
      for (int c = 0; c < 40; c++) begin
         acc = in_valid && in_ready;
         if (out_valid) begin
            if (q.size() > 0) check_output("b2b data", out_data, q.pop_front());
            else check_output("b2b spurious out_valid", out_valid, 0);
         end
         if (acc) begin
            q.push_back(sub_word(in_data, in_inv));
            if (last_acc >= 0) check_output("b2b gap", 128'(c - last_acc), 128'(5));
            last_acc = c;
            n_acc++;
         end
         @(posedge clk); #1;
         if (acc) begin
            in_data = rand_word();
            in_inv  = 1'($urandom_range(1));
         end
      end
      check_output("b2b accepts", 128'(n_acc), 128'(8));
      in_valid = 1'b0;
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
         if (out_valid) check_output("b2b drain data", out_data, q.pop_front());
         @(posedge clk); #1;
      end
      check_output("b2b drained", 128'(q.size()), 128'(0));
      in_inv = 1'b0;

      // Reset pulsed at beat 2 of SUB
      in_valid = 1'b1; in_data = rand_word(); in_inv = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_output("midreset out_valid", out_valid, 0);
      check_output("midreset out_data", out_data, 0);
      check_output("midreset in_ready", in_ready, 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check_output("postreset in_ready", in_ready, 1);
      check_output("postreset out_valid", out_valid, 0);
      d = rand_word();
      apply_stimulus(d, 1'b0, res, lat);
      check_output("postreset data", res, sub_word(d, 1'b0));
      check_output("postreset latency", 128'(lat), 128'(4));

      // Lane sweep: LANES=1 and LANES=16 on the same words
      for (int m = 0; m < 2; m++) begin
         d = rand_word();
         check_output("sweep l1 ready", rdy_l1, 1);
         check_output("sweep l16 ready", rdy_l16, 1);
         sw_valid = 1'b1; in_data = d; in_inv = 1'(m);
         @(posedge clk); #1;
         sw_valid = 1'b0; in_inv = ~1'(m);
         got1 = 1'b0; got16 = 1'b0; lat1 = 99; lat16 = 99;
         for (int c = 0; c < 40; c++) begin
            if (ov_l1 && !got1) begin
               got1 = 1'b1; lat1 = c;
               check_output($sformatf("sweep%0d l1 data", m), od_l1, sub_word(d, 1'(m)));
            end
            if (ov_l16 && !got16) begin
               got16 = 1'b1; lat16 = c;
               check_output($sformatf("sweep%0d l16 data", m), od_l16, sub_word(d, 1'(m)));
            end
            @(posedge clk); #1;
         end
         check_output($sformatf("sweep%0d l1 latency", m), 128'(lat1), 128'(16));
         check_output($sformatf("sweep%0d l16 latency", m), 128'(lat16), 128'(1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/aes_sbox_array.md
AES_SBOX_ARRAY -- requirements
Module: aes_sbox_array

Interface
REQ-001 SHALL have parameter NBYTES, default 16: number of bytes per data word.
REQ-002 SHALL have parameter LANES, default 4: number of S-box lookups performed per cycle.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream word is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-007 SHALL have port in_inv, input, 1 bit: mode select, 0 = forward S-box, 1 = inverse S-box.
REQ-008 SHALL have port in_data, input, 8*NBYTES bits: byte i is in bits [8i+7:8i].
REQ-009 SHALL have port out_valid, output, 1 bit: the result word is present.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_data, output, 8*NBYTES bits: the substituted word, with the same byte ordering as in_data.

Function
REQ-012 SHALL transfer a word on any rising edge where in_valid && in_ready, latching in_data and in_inv.
REQ-013 SHALL implement a three-state FSM: IDLE, SUB and DONE.
REQ-014 SHALL make in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-015 SHALL, on an accept, go to SUB with beat counter = 0.
REQ-016 SHALL, in SUB, replace bytes [beat*LANES .. beat*LANES+LANES-1] of the working register with S(byte) or S^-1(byte) each cycle, then increment beat.
REQ-017 SHALL, in SUB at beat == BEATS-1, where BEATS = NBYTES/LANES, go to DONE with beat cleared to 0.
REQ-018 SHALL give a latency of BEATS cycles from the accepting edge to the first cycle with out_valid=1; with LANES==NBYTES this is 1 cycle.
REQ-019 SHALL assert out_valid only in DONE.
REQ-020 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL, in DONE with out_ready=1 and in_valid=0, go to IDLE.
REQ-022 SHALL, in DONE with out_ready=1 and in_valid=1, retire the old word and accept the new word on the same edge, going straight to SUB (no bubble).
REQ-023 SHALL use the mode latched at accept for the whole operation; in_inv changes in SUB or DONE SHALL be ignored.
REQ-024 SHALL compute forward and inverse S-box values exactly per FIPS-197 (e.g. S(0x00)=0x63, S(0x53)=0xED, S^-1(0x63)=0x00).
REQ-025 SHALL treat NBYTES % LANES != 0, LANES < 1 or LANES > NBYTES as an elaboration error.
REQ-026 SHALL present out_data as the full working register; bytes not yet substituted are never visible, because out_valid=0 outside DONE.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-SUB, immediately force: state=IDLE, beat=0, out_valid=0, out_data=0, mode register=0; any in-flight word SHALL be discarded.
REQ-028 SHALL drive in_ready=1 while in reset-released IDLE; in_ready SHALL be 0 while rst_n=0.

Structure
REQ-029 SHALL place the 256-entry forward and inverse S-box constant tables and the FSM state encoding in the shared package aes_pkg.
REQ-030 SHALL instantiate LANES copies of one sub-module, aes_sbox_lane (8-bit in, inv select, 8-bit out, purely combinational).
REQ-031 SHALL have all sequential logic, including the FSM, beat counter, working register and mode register, reside in aes_sbox_array.

Verification
REQ-032 SHALL cover: defaults, forward mode, in_data bytes 0x00..0x0F -> after 4 cycles out_data bytes 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76.
REQ-033 SHALL cover: inverse mode on the REQ-032 output -> bytes 0x00..0x0F returned; all 256 byte values round-trip forward-then-inverse.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_data stable, in_ready=0, no new accept; on release, word retired in one cycle.
REQ-035 SHALL cover: back-to-back, in_valid and out_ready held 1 -> one word accepted every BEATS+... i.e. every 5 cycles with defaults, no bubble cycle in IDLE.
REQ-036 SHALL cover: rst_n pulsed low at beat 2 -> out_valid=0 and in_ready=1 after release; the next word processes correctly with no stale bytes.
REQ-037 SHALL cover: parameter sweep LANES in {1,4,16} -> latency 16, 4 and 1 cycles respectively, with identical data results.
